// File: rtl/hilo_pkg.sv
// hilo_pkg: shared width, default timeout and FSM encoding for the HI/LO controller.
package hilo_pkg;
  localparam int DATA_W = 32;
  localparam int TIMEOUT_CYCLES_DEF = 40;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    ABORT   = 3'd4
  } state_e;
endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO register pair with independent writes.
// HILO_BYPASS_EN forwards write data to the outputs in the write cycle.
module hilo_regs
  import hilo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_wd,
  input  logic [DATA_W-1:0] lo_wd,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  logic [DATA_W-1:0] hi_q, lo_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wd;
      if (lo_we) lo_q <= lo_wd;
    end
  end
`ifdef HILO_BYPASS_EN
  assign hi = hi_we ? hi_wd : hi_q;
  assign lo = lo_we ? lo_wd : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: launches a multiply, waits for the result with a timeout and owns HI/LO.
// Define HILO_BYPASS_EN to make HI/LO writes visible combinationally in the write cycle.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_mult,
  input  logic              op_mthi,
  input  logic              op_mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mult_end,
  input  logic [DATA_W-1:0] mult_high,
  input  logic [DATA_W-1:0] mult_low,
  output logic              mult_start,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               start_q, done_q, err_q, err_d;
  logic               hi_we, lo_we;
  logic [DATA_W-1:0]  hi_wd, lo_wd;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    err_d   = err_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_wd   = wdata;
    lo_wd   = wdata;
    case (state_q)
      IDLE: begin
        if (op_mult) begin
          state_d = LAUNCH;
          err_d   = 1'b0;
        end else begin
          hi_we = op_mthi;
          lo_we = op_mtlo;
        end
      end
      LAUNCH: begin
        armed_d = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // a stale done level from the previous op must drop before it can count
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        armed_d = armed_q | ~mult_end;
        state_d = (armed_q && mult_end) ? CAPTURE
                : (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) ? ABORT : WAIT;
      end
      CAPTURE: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_wd   = mult_high;
        lo_wd   = mult_low;
        state_d = IDLE;
      end
      ABORT: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      start_q <= state_d == LAUNCH;
      done_q  <= state_q == CAPTURE;
      err_q   <= err_d;
    end
  end
  assign mult_start = start_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = state_q != IDLE;
  hilo_regs u_regs (
    .clk   (clk),
    .reset (reset),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_wd (hi_wd),
    .lo_wd (lo_wd),
    .hi    (hi),
    .lo    (lo)
  );
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed bench for hilo_ctrl with a behavioural multiplier model.
module tb_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset, op_mult, op_mthi, op_mtlo, mult_end;
  logic [31:0] wdata, mult_high, mult_low, hi, lo;
  logic        mult_start, busy, done, err;
  int          n_chk = 0, n_err = 0;
  longint      m_prod;
  int          m_lat, m_stale, m_cnt, m_hold;
  bit          m_resp;
  always #5 clk = ~clk;
  hilo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op_mult    (op_mult),
    .op_mthi    (op_mthi),
    .op_mtlo    (op_mtlo),
    .wdata      (wdata),
    .mult_end   (mult_end),
    .mult_high  (mult_high),
    .mult_low   (mult_low),
    .mult_start (mult_start),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );
  // multiplier: drops done after m_stale cycles, raises it m_lat cycles after start
  initial begin
    mult_end = 1'b0;
    mult_high = '0;
    mult_low = '0;
    m_cnt = 0;
    m_hold = 0;
    forever begin
      @(negedge clk);
      if (mult_start) begin
        m_cnt = m_lat;
        m_hold = m_stale;
        if (m_stale == 0) mult_end = 1'b0;
      end else begin
        if (m_hold > 0) begin
          m_hold--;
          if (m_hold == 0) mult_end = 1'b0;
        end
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0 && m_resp) begin
            mult_end = 1'b1;
            mult_high = m_prod[63:32];
            mult_low = m_prod[31:0];
          end
        end
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_mult(input int a, input int b, input int lat, input int stale, input string tag);
    longint p;
    int cyc, starts;
    bit busy_ok;
    p = longint'(a) * longint'(b);
    m_prod = p;
    m_lat = lat;
    m_stale = stale;
    m_resp = 1'b1;
    op_mult = 1'b1;
    tick;
    op_mult = 1'b0;
    cyc = 1;
    starts = 0;
    busy_ok = 1'b1;
    check({tag, "_start"}, 64'(mult_start), 64'd1);
    check({tag, "_errclr"}, 64'(err), 64'd0);
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick;
      cyc++;
      if (mult_start) starts++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lat + 3));
    check({tag, "_starts"}, 64'(starts), 64'd0);
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(p[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(p[31:0]));
    tick;
    check({tag, "_done1"}, 64'(done), 64'd0);
  endtask
  initial begin
    int cyc, dones;
    reset = 1'b0;
    op_mult = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    wdata = '0;
    m_prod = 0;
    m_lat = 5;
    m_stale = 0;
    m_resp = 1'b1;
    tick;
    tick;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(mult_start), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick;
    run_mult(7, -3, 5, 0, "m1");
    check("m1_hiconst", 64'(hi), 64'hFFFFFFFF);
    check("m1_loconst", 64'(lo), 64'hFFFFFFEB);
    run_mult(6, 5, 6, 3, "b2b");
    check("b2b_loconst", 64'(lo), 64'd30);
    m_resp = 1'b0;
    m_stale = 0;
    op_mult = 1'b1;
    tick;
    op_mult = 1'b0;
    cyc = 1;
    while (!err && cyc < 100) begin
      tick;
      cyc++;
    end
    check("abort_cyc", 64'(cyc), 64'd43);
    check("abort_err", 64'(err), 64'd1);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd30);
    check("abort_busy", 64'(busy), 64'd0);
    tick;
    check("abort_sticky", 64'(err), 64'd1);
    run_mult(65536, 65536, 4, 0, "clr");
    op_mthi = 1'b1;
    op_mtlo = 1'b1;
    wdata = 32'hDEADBEEF;
    tick;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    check("mt_hi", 64'(hi), 64'hDEADBEEF);
    check("mt_lo", 64'(lo), 64'hDEADBEEF);
    m_prod = 12;
    m_lat = 6;
    m_resp = 1'b1;
    op_mult = 1'b1;
    op_mthi = 1'b1;
    op_mtlo = 1'b1;
    wdata = 32'h12345678;
    tick;
    op_mult = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    check("drop_hi", 64'(hi), 64'hDEADBEEF);
    check("drop_lo", 64'(lo), 64'hDEADBEEF);
    tick;
    op_mthi = 1'b1;
    wdata = 32'h11111111;
    tick;
    op_mthi = 1'b0;
    check("wait_mthi", 64'(hi), 64'hDEADBEEF);
    cyc = 3;
    while (!done && cyc < 100) begin
      tick;
      cyc++;
    end
    check("m3_lat", 64'(cyc), 64'd9);
    check("m3_hi", 64'(hi), 64'd0);
    check("m3_lo", 64'(lo), 64'd12);
    tick;
    m_prod = 63;
    m_lat = 10;
    op_mult = 1'b1;
    tick;
    op_mult = 1'b0;
    tick;
    tick;
    check("rw_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick;
    check("rw_hi", 64'(hi), 64'd0);
    check("rw_lo", 64'(lo), 64'd0);
    check("rw_busy0", 64'(busy), 64'd0);
    check("rw_start", 64'(mult_start), 64'd0);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done) dones++;
    end
    check("rw_nocap", 64'(dones), 64'd0);
    check("rw_hi2", 64'(hi), 64'd0);
    check("rw_lo2", 64'(lo), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
